// File: rtl/mem_port_arbiter_if.sv
// Shared-RAM port bundle: fetch requester, data requester and RAM side.
// slave  = arbiter view, master = requesters/RAM view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32
);
  // Fetch side
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  // Data side
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  // RAM side
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output ram_addr, ram_wdata, ram_wren,
    input  ram_rdata
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  ram_addr, ram_wdata, ram_wren,
    output ram_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the single-ported instruction/data RAM.
// One access per cycle, 1-cycle read responses routed to their owner,
// fetch squash on branch flush, bounded fetch starvation.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mem_port_arbiter_if.slave       bus
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic              run_q;
  logic [1:0]        pend_q,   pend_d;
  logic [3:0]        starve_q, starve_d;
  logic [DATA_W-1:0] if_hold_q, if_hold_d;
  logic [DATA_W-1:0] d_hold_q,  d_hold_d;

  logic if_elig, d_elig;
  logic if_gnt, d_gnt;
  logic if_resp, d_resp;

  // Grant selection: data normally wins, fetch wins once the starvation budget is spent
  always_comb begin
    if_elig = run_q & bus.if_req & ~bus.if_flush;
    d_elig  = run_q & bus.d_req;
    if_gnt  = 1'b0;
    d_gnt   = 1'b0;
    if (if_elig && d_elig) begin
      if (starve_q >= LIMIT) if_gnt = 1'b1;
      else                   d_gnt  = 1'b1;
    end else begin
      if_gnt = if_elig;
      d_gnt  = d_elig;
    end
  end

  // RAM port drive; address parks at zero when idle
  always_comb begin
    bus.ram_wdata = bus.d_wdata;
    bus.ram_wren  = d_gnt & bus.d_we;
    if (if_gnt)     bus.ram_addr = bus.if_addr;
    else if (d_gnt) bus.ram_addr = bus.d_addr;
    else            bus.ram_addr = '0;
    bus.if_gnt = if_gnt;
    bus.d_gnt  = d_gnt;
  end

  // Response routing; holding registers supply read data outside response cycles
  always_comb begin
    if_resp       = (pend_q == OWN_IF);
    d_resp        = (pend_q == OWN_D);
    bus.if_rvalid = if_resp & ~bus.if_flush;
    bus.if_rdata  = if_resp ? bus.ram_rdata : if_hold_q;
    bus.d_rvalid  = d_resp;
    bus.d_rdata   = d_resp ? bus.ram_rdata : d_hold_q;
    if_hold_d     = (if_resp && !bus.if_flush) ? bus.ram_rdata : if_hold_q;
    d_hold_d      = d_resp ? bus.ram_rdata : d_hold_q;
  end

  // Next-state for read ownership and the starvation counter
  always_comb begin
    if (if_gnt)                  pend_d = OWN_IF;
    else if (d_gnt && !bus.d_we) pend_d = OWN_D;
    else                         pend_d = OWN_NONE;

    if (d_gnt && if_elig)
      starve_d = (starve_q >= LIMIT) ? LIMIT : starve_q + 4'd1;
    else if (if_gnt || !if_elig)
      starve_d = '0;
    else
      starve_d = starve_q;
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q     <= 1'b0;
      pend_q    <= OWN_NONE;
      starve_q  <= '0;
      if_hold_q <= '0;
      d_hold_q  <= '0;
    end else begin
      run_q     <= 1'b1;
      pend_q    <= pend_d;
      starve_q  <= starve_d;
      if_hold_q <= if_hold_d;
      d_hold_q  <= d_hold_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural RAM, read-data scoreboard, directed scenarios.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural synchronous RAM: address and write registered on the edge
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] sh  [0:(1<<AW)-1];
  logic [AW-1:0] raddr_q = '0;

  always @(posedge clk) begin
    if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_wdata;
    raddr_q <= bus.ram_addr;
  end
  assign bus.ram_rdata = mem[raddr_q];

  function automatic logic [DW-1:0] f(input int unsigned i);
    return 32'hE3A01005 ^ (i << 16);
  endfunction

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Scoreboard: expectations pushed at grant, popped in the response cycle
  logic [DW-1:0] if_q [$];
  logic [DW-1:0] d_q  [$];
  logic          if_due = 1'b0;
  logic          d_due  = 1'b0;
  logic [DW-1:0] last_if = '0;
  logic [DW-1:0] last_d  = '0;

  always @(negedge clk) begin
    logic [DW-1:0] e;
    logic [AW-1:0] ea;
    if (!rst_n) begin
      chk("rst_ctrl", {bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.ram_wren}, '0);
      chk("rst_data", {bus.if_rdata, bus.d_rdata}, '0);
      if_q.delete(); d_q.delete();
      if_due = 1'b0; d_due = 1'b0;
      last_if = '0;  last_d = '0;
    end else begin
      if (if_due) begin
        e = (if_q.size() > 0) ? if_q.pop_front() : 'x;
        chk("if_rvalid", bus.if_rvalid, !bus.if_flush);
        if (!bus.if_flush) begin
          chk("if_rdata", bus.if_rdata, e);
          last_if = e;
        end
      end else begin
        chk("if_rvalid_idle", bus.if_rvalid, 1'b0);
        chk("if_rdata_hold", bus.if_rdata, last_if);
      end
      if (d_due) begin
        e = (d_q.size() > 0) ? d_q.pop_front() : 'x;
        chk("d_rvalid", bus.d_rvalid, 1'b1);
        chk("d_rdata", bus.d_rdata, e);
        last_d = e;
      end else begin
        chk("d_rvalid_idle", bus.d_rvalid, 1'b0);
        chk("d_rdata_hold", bus.d_rdata, last_d);
      end
      chk("gnt_excl", bus.if_gnt & bus.d_gnt, 1'b0);
      chk("gnt_flush", bus.if_gnt & bus.if_flush, 1'b0);
      ea = bus.if_gnt ? bus.if_addr : (bus.d_gnt ? bus.d_addr : '0);
      chk("ram_addr", bus.ram_addr, ea);
      chk("ram_wren", bus.ram_wren, bus.d_gnt & bus.d_we);
      if_due = bus.if_gnt;
      if (bus.if_gnt) if_q.push_back(sh[bus.if_addr]);
      d_due = bus.d_gnt & ~bus.d_we;
      if (d_due) d_q.push_back(sh[bus.d_addr]);
      if (bus.d_gnt && bus.d_we) sh[bus.d_addr] = bus.d_wdata;
    end
  end

  initial begin
    bit exp_d;
    for (int unsigned i = 0; i < (1 << AW); i++) begin
      mem[i] = f(i);
      sh[i]  = f(i);
    end
    bus.if_req = 1'b1; bus.if_addr = '0; bus.if_flush = 1'b0;
    bus.d_req = 1'b0;  bus.d_we = 1'b0;  bus.d_addr = '0; bus.d_wdata = '0;

    // Reset with fetch requesting: everything zero without a clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", {bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.ram_wren}, '0);
    chk("async_rst_data", {bus.ram_addr, bus.if_rdata, bus.d_rdata}, '0);
    repeat (2) tick();
    rst_n = 1'b1;                      // release cycle 0
    neg(); chk("cyc0_no_gnt", bus.if_gnt, 1'b0);
    tick(); neg(); chk("cyc1_if_gnt", bus.if_gnt, 1'b1);
    tick(); bus.if_req = 1'b0;
    neg(); chk("cyc2_rvalid", bus.if_rvalid, 1'b1);
    chk("cyc2_rdata", bus.if_rdata, 32'hE3A01005);
    tick();

    // Back-to-back fetches at addresses 0..3
    for (int unsigned i = 0; i < 4; i++) begin
      bus.if_req = 1'b1; bus.if_addr = AW'(i);
      neg(); chk("b2b_gnt", bus.if_gnt, 1'b1);
      if (i > 0) chk("b2b_rvalid", bus.if_rvalid, 1'b1);
      tick();
    end
    bus.if_req = 1'b0;
    neg(); chk("b2b_last_rvalid", bus.if_rvalid, 1'b1); chk("b2b_last_rdata", bus.if_rdata, f(3));
    tick(); neg(); chk("b2b_hold", bus.if_rdata, f(3)); chk("b2b_done", bus.if_rvalid, 1'b0);
    tick();

    // Anti-starvation: both requesting continuously -> D,D,D,IF
    bus.if_req = 1'b1; bus.if_addr = AW'(7);
    bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = AW'(9);
    for (int unsigned k = 0; k < 12; k++) begin
      exp_d = (k % 4) != 3;
      neg(); chk("starve_d_gnt", bus.d_gnt, exp_d); chk("starve_if_gnt", bus.if_gnt, !exp_d);
      tick();
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    neg(); tick();

    // Store then load of the same address
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = AW'(16); bus.d_wdata = 32'hDEADBEEF;
    neg(); chk("st_gnt", bus.d_gnt, 1'b1); chk("st_wren", bus.ram_wren, 1'b1);
    tick(); bus.d_we = 1'b0;
    neg(); chk("ld_gnt", bus.d_gnt, 1'b1); chk("ld_wren", bus.ram_wren, 1'b0);
    tick(); bus.d_req = 1'b0;
    neg(); chk("ld_rvalid", bus.d_rvalid, 1'b1); chk("ld_rdata", bus.d_rdata, 32'hDEADBEEF);
    tick(); neg(); chk("ld_hold", bus.d_rdata, 32'hDEADBEEF); chk("ld_done", bus.d_rvalid, 1'b0);
    tick();

    // Flush in the response cycle, then flush blocking a fetch request
    bus.if_req = 1'b1; bus.if_addr = AW'(5);
    neg(); chk("fl_gnt", bus.if_gnt, 1'b1);
    tick(); bus.if_req = 1'b0; bus.if_flush = 1'b1;
    neg(); chk("fl_rvalid", bus.if_rvalid, 1'b0);
    tick(); bus.if_req = 1'b1;
    neg(); chk("fl_hold", bus.if_rdata, f(7));
    chk("fl_no_gnt", {bus.if_gnt, bus.d_gnt, bus.ram_wren}, '0);
    tick(); bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = AW'(16);
    neg(); chk("fl_d_slot", bus.d_gnt, 1'b1); chk("fl_if_blocked", bus.if_gnt, 1'b0);
    tick(); bus.if_req = 1'b0; bus.if_flush = 1'b0; bus.d_req = 1'b0;
    neg(); chk("fl_d_rdata", bus.d_rdata, 32'hDEADBEEF);
    tick();

    // Reset during a load response
    bus.d_req = 1'b1; bus.d_addr = AW'(9);
    neg(); chk("mr_gnt", bus.d_gnt, 1'b1);
    tick(); bus.d_req = 1'b0;
    chk("mr_rvalid_pre", bus.d_rvalid, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk("mr_rvalid_rst", bus.d_rvalid, 1'b0); chk("mr_rdata_rst", bus.d_rdata, '0);
    tick(); rst_n = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      neg(); chk("mr_rvalid_after", bus.d_rvalid, 1'b0);
      tick();
    end
    neg();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the CPU's single-ported synchronous instruction/data RAM. It shares the RAM port between the fetch stage (instruction reads) and the memory stage (LDR/STR data accesses). It issues at most one access per cycle and routes each 1-cycle-latency read response back to its owner. It also squashes in-flight fetches on a branch and prevents fetch starvation under sustained data traffic.

## Interface
- ADDR_W, default 11: RAM word-address width.
- DATA_W, default 32: data width.
- STARVE_LIMIT, default 3: consecutive data grants allowed while fetch waits. Legal range is 1..15.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- if_req  in  1  fetch read request, level.
- if_addr  in  ADDR_W  fetch word address.
- if_flush  in  1  branch taken; squash fetch traffic.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  DATA_W  fetch read data.
- d_req  in  1  data access request, level.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data request accepted this cycle; for stores this is the completion.
- d_rvalid  out  1  load data valid.
- d_rdata  out  DATA_W  load data.
- ram_addr  out  ADDR_W  RAM address; RAM registers it on the clk edge.
- ram_wdata  out  DATA_W  RAM write data.
- ram_wren  out  1  RAM write enable.
- ram_rdata  in  DATA_W  RAM read data, valid in the cycle after the address was presented.

## Operation
- Internal state:
  - run: cleared by reset, set on the first clk edge after reset release.
  - pend_own: none / IF / D, the owner of the read issued last cycle.
  - starve_cnt: 4 bits.
  - if_hold and d_hold: DATA_W-wide holding registers.
- Grant is combinational within the cycle. Nothing is granted while run=0.
- A fetch is eligible when if_req=1 and if_flush=0.
- Selection when both requesters are eligible:
  - Data wins if starve_cnt < STARVE_LIMIT.
  - Fetch wins if starve_cnt == STARVE_LIMIT.
- A single eligible requester always wins.
- RAM drive:
  - Winner's address goes to ram_addr.
  - ram_wdata = d_wdata.
  - ram_wren = d_gnt & d_we.
  - With no grant, ram_addr holds 0 and ram_wren = 0.
- starve_cnt update at the clk edge:
  - Increments, saturating at STARVE_LIMIT, when d_gnt=1 and a fetch was eligible.
  - Clears when if_gnt=1 or no fetch was eligible.
- pend_own at the clk edge:
  - IF if if_gnt.
  - D if d_gnt & ~d_we.
  - Otherwise none.
- Response cycle when pend_own = IF:
  - if_rvalid = ~if_flush.
  - if_rdata = ram_rdata.
  - if_hold captures ram_rdata at the end of the cycle, only when if_rvalid=1.
- Response cycle when pend_own = D:
  - d_rvalid = 1, d_rdata = ram_rdata, d_hold captures.
  - Flush never affects data.
- Outside response cycles, if_rdata = if_hold and d_rdata = d_hold.
- A new grant may be issued in the same cycle as a response, so back-to-back reads reach full throughput.
- Requesters hold req/addr/wdata stable until they see their gnt.

## Timing
- Reset (async assert): all of the following are 0 immediately, with no clk edge needed:
  - run, pend_own, starve_cnt, if_hold, d_hold.
  - if_gnt, d_gnt, if_rvalid, d_rvalid, ram_wren, ram_addr, if_rdata, d_rdata.
- First grant is possible in cycle 1 after reset release, counting the release cycle as 0.
- Read latency is exactly 1 cycle: grant in cycle N gives rvalid in cycle N+1.
- Store latency is 0: the write occurs at the edge ending the d_gnt cycle.
- Store followed immediately by a load to the same address: the load returns the new data (the RAM is write-first across cycles).
- Flush in the grant cycle prevents the fetch grant, and data may take the slot. Flush in the response cycle suppresses if_rvalid and leaves if_hold unchanged.
- Reset mid-response: the pending response is discarded and no rvalid appears after release.
- Worst-case fetch wait under continuous data requests is STARVE_LIMIT cycles.

## Test plan
- Reset and startup: assert rst_n=0 with if_req=1 → all outputs 0. Release rst_n → if_gnt first appears in cycle 1; if_rvalid in cycle 2 with ram_rdata, e.g. 0xE3A01005.
- Back-to-back fetches: if_req held for 4 cycles with addresses 0..3 → if_gnt=1 for 4 cycles. if_rvalid=1 for 4 cycles, each one cycle later, with data in order. After the last response, if_rdata holds the last word.
- Priority and anti-starvation: if_req and d_req held continuously, STARVE_LIMIT=3 → grant pattern D,D,D,IF repeating.
- Store then load: store 0xDEADBEEF to address 0x10 (d_gnt=1, ram_wren=1 for one cycle), then load 0x10 → d_rvalid next cycle with d_rdata=0xDEADBEEF, and d_rdata held afterwards.
- Flush: fetch granted in cycle N with if_flush=1 in N+1 → no if_rvalid and if_rdata unchanged. if_flush=1 with if_req=1 and d_req=0 → no grant and ram_wren=0.
- Mid-operation reset: load granted, then rst_n=0 during the response cycle → d_rvalid=0 immediately and stays 0 after release until a new grant.
